pc_sequencer: RTL and testbench

Program-counter sequencer for the 16-bit CPU. It holds the architectural PC and fetches one instruction at a time from instruction memory over a req/ack handshake. After each fetch it selects the next PC: sequential +2, relative branch, or absolute jump. It sits between the instruction memory port and the decode/execute stage, and owns the PC increment adder path.

---
 rtl/pc_sequencer.sv | 123 ++++++++++++
 tb/tb_pc_sequencer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program-counter sequencer with req/ack instruction fetch
//
// Optional feature macro: PC_ALIGN_CHECK_EN
//   defined   : odd redirect targets are rejected, misalign latches, FSM halts
//   undefined : bit0 of every redirect target is cleared, misalign tied 0
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   stall           EXEC holds the current instruction while high
//   branch_taken    relative branch request, sampled in EXEC with stall=0
//   branch_offset   signed word offset (byte displacement = offset<<1)
//   jump            absolute jump request, sampled in EXEC with stall=0
//   jump_target     absolute byte address
//   imem_req        fetch request, high for the whole FETCH state
//   imem_addr       fetch address, always equal to pc
//   imem_ack        fetch accepted/returned (observed in FETCH only)
//   instr_valid     fetched instruction available to decode (EXEC state)
//   pc, pc_plus2    current PC and pc + 2 modulo 2^16
//   pc_wrap         sticky, set when a sequential step wraps FFFE -> 0000
//   misalign        sticky misaligned-redirect flag

module pc_sequencer #(
  parameter logic [15:0] RESET_VECTOR = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_offset,
  input  logic        jump,
  input  logic [15:0] jump_target,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  output logic        instr_valid,
  output logic [15:0] pc,
  output logic [15:0] pc_plus2,
  output logic        pc_wrap,
  output logic        misalign
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_EXEC  = 2'd2;
`ifdef PC_ALIGN_CHECK_EN
  localparam logic [1:0] S_HALT  = 2'd3;
`endif

  logic [1:0]  state;
  logic [15:0] seq_pc;
  logic [15:0] branch_pc;
  logic [15:0] target;
  logic [15:0] load_target;
  logic        redirect;

  // Shared increment adder feeds both the sequential path and pc_plus2.
  always_comb begin
    seq_pc    = pc + 16'd2;
    branch_pc = seq_pc + (branch_offset << 1);
    redirect  = jump | branch_taken;
    // jump outranks branch
    target    = jump ? jump_target : branch_pc;
`ifdef PC_ALIGN_CHECK_EN
    load_target = target;
`else
    load_target = target & 16'hFFFE;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      pc      <= RESET_VECTOR;
      pc_wrap <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
      misalign <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: state <= S_FETCH;
        S_FETCH: begin
          if (imem_ack) state <= S_EXEC;
        end
        S_EXEC: begin
          if (!stall) begin
`ifdef PC_ALIGN_CHECK_EN
            if (redirect && target[0]) begin
              // pc keeps its value; only reset leaves HALT
              misalign <= 1'b1;
              state    <= S_HALT;
            end else
`endif
            begin
              state <= S_FETCH;
              if (redirect) begin
                pc <= load_target;
              end else begin
                pc <= seq_pc;
                // only the sequential path reports wrap
                if (pc == 16'hFFFE) pc_wrap <= 1'b1;
              end
            end
          end
        end
`ifdef PC_ALIGN_CHECK_EN
        S_HALT: state <= S_HALT;
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

  // Outputs decode registered state and pc only.
  assign imem_req    = (state == S_FETCH);
  assign instr_valid = (state == S_EXEC);
  assign imem_addr   = pc;
  assign pc_plus2    = seq_pc;

`ifndef PC_ALIGN_CHECK_EN
  assign misalign = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - self-checking bench for pc_sequencer

module tb_pc_sequencer;

  localparam logic [15:0] RV = 16'h0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_offset;
  logic        jump;
  logic [15:0] jump_target;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic        instr_valid;
  logic [15:0] pc;
  logic [15:0] pc_plus2;
  logic        pc_wrap;
  logic        misalign;

  int total = 0;
  int bad   = 0;

  pc_sequencer #(.RESET_VECTOR(RV)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .branch_taken(branch_taken), .branch_offset(branch_offset),
    .jump(jump), .jump_target(jump_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .instr_valid(instr_valid), .pc(pc), .pc_plus2(pc_plus2),
    .pc_wrap(pc_wrap), .misalign(misalign)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] start_pc;
    logic        j;
    logic [15:0] jt;
    logic        b;
    logic [15:0] bo;
    logic [15:0] exp_pc;
    logic        exp_wrap;
  } vec_t;

  vec_t vecs[9];

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_offset = 16'h0000;
    jump          = 1'b0;
    jump_target   = 16'h0000;
    imem_ack      = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    chk16("rst_pc", pc, RV);
    chk16("rst_pc_plus2", pc_plus2, RV + 16'd2);
    chk1("rst_req", imem_req, 1'b0);
    chk1("rst_valid", instr_valid, 1'b0);
    chk1("rst_wrap", pc_wrap, 1'b0);
    chk1("rst_misalign", misalign, 1'b0);
    rst = 1'b0;
    tick();
    chk1("first_req", imem_req, 1'b1);
    chk16("first_addr", imem_addr, RV);
  endtask

  // Complete one fetch (zero-wait ack) and one unstalled EXEC with the given redirect.
  task automatic run_instr(input logic j, input logic [15:0] jt, input logic b, input logic [15:0] bo);
    int n = 0;
    while (!imem_req && n < 20) begin
      tick();
      n++;
    end
    chk1("fetch_wait", imem_req, 1'b1);
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    chk1("exec_entry", instr_valid, 1'b1);
    stall        = 1'b0;
    jump         = j;
    jump_target  = jt;
    branch_taken = b;
    branch_offset = bo;
    tick();
    jump         = 1'b0;
    branch_taken = 1'b0;
  endtask

  // Reference: next pc from the architectural rules, in plain integer arithmetic.
  logic [15:0] mdl_pc;
  logic        mdl_wrap;
  logic        mdl_fetching;

  task automatic model_step();
    int t;
    if (jump) begin
      mdl_pc = jump_target & 16'hFFFE;
    end else if (branch_taken) begin
      t = int'(mdl_pc) + 2 + 2 * int'($signed(branch_offset));
      mdl_pc = 16'(t & 32'h0000FFFF);
    end else begin
      t = int'(mdl_pc) + 2;
      if (t > 65535) mdl_wrap = 1'b1;
      mdl_pc = 16'(t % 65536);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ack_pat[7];
    logic stall_pat[7];
    logic jump_pat[7];
    int   req_cnt;
    int   iv_cnt;
    int   done_cnt;

    vecs[0] = '{16'h0010, 1'b0, 16'h0000, 1'b1, 16'hFFFC, 16'h000A, 1'b0};
    vecs[1] = '{16'h0010, 1'b1, 16'h0100, 1'b1, 16'hFFFC, 16'h0100, 1'b0};
    vecs[2] = '{16'h0010, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0012, 1'b0};
    vecs[3] = '{16'hFFFE, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b1};
    vecs[4] = '{16'hFFFE, 1'b0, 16'h0000, 1'b1, 16'h0000, 16'h0000, 1'b0};
    vecs[5] = '{16'hFFF0, 1'b0, 16'h0000, 1'b1, 16'h0010, 16'h0012, 1'b0};
    vecs[6] = '{16'h8000, 1'b0, 16'h0000, 1'b1, 16'h7FFF, 16'h8000, 1'b0};
    vecs[7] = '{16'h0000, 1'b1, 16'hFFFE, 1'b0, 16'h0000, 16'hFFFE, 1'b0};
    vecs[8] = '{16'h0100, 1'b0, 16'h0000, 1'b1, 16'h8000, 16'h0102, 1'b0};

    rst = 1'b1;
    clear_inputs();

    // Zero-wait stream: FETCH/EXEC alternate, addresses 0,2,4.
    do_reset();
    imem_ack = 1'b1;
    for (int k = 0; k < 6; k++) begin
      chk1("zw_valid", instr_valid, logic'(k % 2));
      chk1("zw_req", imem_req, logic'(1 - k % 2));
      if (k % 2 == 0) chk16("zw_addr", imem_addr, 16'(k));
      tick();
    end
    imem_ack = 1'b0;

    // Redirect / sequential table.
    for (int i = 0; i < 9; i++) begin
      do_reset();
      run_instr(1'b1, vecs[i].start_pc, 1'b0, 16'h0000);
      chk16("vec_start", pc, vecs[i].start_pc);
      run_instr(vecs[i].j, vecs[i].jt, vecs[i].b, vecs[i].bo);
      chk16("vec_pc", pc, vecs[i].exp_pc);
      chk1("vec_wrap", pc_wrap, vecs[i].exp_wrap);
    end

    // pc_wrap stays set across later instructions until reset.
    do_reset();
    run_instr(1'b1, 16'hFFFE, 1'b0, 16'h0000);
    run_instr(1'b0, 16'h0000, 1'b0, 16'h0000);
    chk16("wrap_pc", pc, 16'h0000);
    chk1("wrap_set", pc_wrap, 1'b1);
    run_instr(1'b0, 16'h0000, 1'b0, 16'h0000);
    run_instr(1'b1, 16'h0040, 1'b0, 16'h0000);
    chk1("wrap_sticky", pc_wrap, 1'b1);
    chk16("wrap_after_pc", pc, 16'h0040);

    // Ack after 3 wait cycles, then 2 stall cycles; redirects outside an unstalled EXEC ignored.
    do_reset();
    ack_pat   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    stall_pat = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    jump_pat  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    req_cnt = 0;
    iv_cnt  = 0;
    for (int k = 0; k < 7; k++) begin
      if (imem_req) req_cnt++;
      if (instr_valid) begin
        iv_cnt++;
        chk16("stall_hold_pc", pc, RV);
      end
      imem_ack    = ack_pat[k];
      stall       = stall_pat[k];
      jump        = jump_pat[k];
      jump_target = 16'h0400;
      tick();
    end
    clear_inputs();
    chk16("wait_req_cycles", 16'(req_cnt), 16'd4);
    chk16("stall_valid_cycles", 16'(iv_cnt), 16'd3);
    chk16("stall_release_pc", pc, RV + 16'd2);
    chk1("stall_release_req", imem_req, 1'b1);

    // Reset during FETCH with a late ack in IDLE.
    do_reset();
    run_instr(1'b0, 16'h0000, 1'b0, 16'h0000);
    chk16("midrst_pre_pc", pc, 16'h0002);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk1("midrst_req_drop", imem_req, 1'b0);
    chk16("midrst_pc", pc, RV);
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    chk1("midrst_no_exec", instr_valid, 1'b0);
    chk1("midrst_req_back", imem_req, 1'b1);
    chk16("midrst_addr", imem_addr, RV);
    tick();
    chk1("midrst_still_fetch", imem_req, 1'b1);

    // Odd jump target.
    do_reset();
    run_instr(1'b1, 16'h0103, 1'b0, 16'h0000);
`ifdef PC_ALIGN_CHECK_EN
    chk16("mis_pc_held", pc, RV);
    chk1("mis_flag", misalign, 1'b1);
    imem_ack = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk1("mis_halt_req", imem_req, 1'b0);
      chk1("mis_halt_valid", instr_valid, 1'b0);
      tick();
    end
    imem_ack = 1'b0;
`else
    chk16("odd_target_pc", pc, 16'h0102);
    chk1("odd_target_misalign", misalign, 1'b0);
`endif

    // Randomized run against the reference model.
    do_reset();
    mdl_pc       = RV;
    mdl_wrap     = 1'b0;
    mdl_fetching = 1'b1;
    done_cnt     = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      chk1("rand_req", imem_req, mdl_fetching);
      chk1("rand_valid", instr_valid, !mdl_fetching);
      chk16("rand_pc", pc, mdl_pc);
      chk16("rand_addr", imem_addr, mdl_pc);
      chk16("rand_pc_plus2", pc_plus2, mdl_pc + 16'd2);
      chk1("rand_wrap", pc_wrap, mdl_wrap);
      imem_ack      = logic'($urandom_range(0, 1));
      stall         = ($urandom_range(0, 9) < 3);
      jump          = ($urandom_range(0, 9) == 0);
      jump_target   = 16'($urandom) & 16'hFFFE;
      branch_taken  = ($urandom_range(0, 4) == 0);
      branch_offset = 16'($urandom);
      if (mdl_fetching) begin
        if (imem_ack) mdl_fetching = 1'b0;
      end else if (!stall) begin
        model_step();
        mdl_fetching = 1'b1;
        done_cnt++;
      end
      tick();
    end
    clear_inputs();
    chk1("rand_progress", done_cnt > 100, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
